// File: rtl/exec_mulshift_unit.sv
// Multi-cycle multiply / shift / rotate unit that sits between the register file read ports and its write port.
// It does one shift-add or one 1-bit shift per RUN cycle, then writes back for a single WB cycle.
module exec_mulshift_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        OP,
  input  logic [DATA_W-1:0] OPERAND1,
  input  logic [DATA_W-1:0] OPERAND2,
  input  logic [ADDR_W-1:0] DEST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [DATA_W-1:0] RESULT,
  output logic [ADDR_W-1:0] WADDR,
  output logic              WRITE,
  output logic [1:0]        dbg_state
);

  // Handshake: START is a single-cycle request taken only while the FSM is IDLE;
  // WRITE and DONE pulse together for exactly one cycle per accepted operation.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] dest_q;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  logic              op_legal;
  logic [CNT_W-1:0]  n_load;
  logic [DATA_W-1:0] acc_step;
  logic [DATA_W-1:0] opa_step;
  logic [DATA_W-1:0] opb_step;

  assign op_legal  = (OP <= OP_ROR);
  assign dbg_state = state;

  // Shift amounts of DATA_W or more saturate: DATA_W single-bit shifts already flush the value.
  always_comb begin
    n_load = FULL_CNT;
    case (OP)
      OP_MUL:  n_load = FULL_CNT;
      OP_ROR:  n_load = CNT_W'(OPERAND2[SH_W-1:0]);
      default: n_load = (OPERAND2 >= DATA_W'(DATA_W)) ? FULL_CNT : CNT_W'(OPERAND2);
    endcase
  end

  always_comb begin
    acc_step = acc;
    opa_step = opa;
    opb_step = opb;
    case (op_q)
      OP_MUL: begin
        if (opb[0]) acc_step = acc + opa;
        opa_step = {opa[DATA_W-2:0], 1'b0};
        opb_step = {1'b0, opb[DATA_W-1:1]};
      end
      OP_SLL:  opa_step = {opa[DATA_W-2:0], 1'b0};
      OP_SRL:  opa_step = {1'b0, opa[DATA_W-1:1]};
      OP_SRA:  opa_step = {opa[DATA_W-1], opa[DATA_W-1:1]};
      OP_ROR:  opa_step = {opa[0], opa[DATA_W-1:1]};
      default: opa_step = opa;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      op_q   <= '0;
      dest_q <= '0;
      count  <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERROR  <= 1'b0;
      WRITE  <= 1'b0;
      RESULT <= '0;
      WADDR  <= '0;
    end else begin
      DONE  <= 1'b0;
      WRITE <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (op_legal) begin
              op_q   <= OP;
              dest_q <= DEST;
              count  <= n_load;
              acc    <= '0;
              opa    <= OPERAND1;
              opb    <= OPERAND2;
              BUSY   <= 1'b1;
              state  <= S_RUN;
            end else begin
              ERROR <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (count != '0) begin
            acc   <= acc_step;
            opa   <= opa_step;
            opb   <= opb_step;
            count <= count - 1'b1;
          end else begin
            RESULT <= (op_q == OP_MUL) ? acc : opa;
            WADDR  <= dest_q;
            WRITE  <= 1'b1;
            DONE   <= 1'b1;
            state  <= S_WB;
          end
        end
        S_WB: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mulshift_unit.sv
// Bench for exec_mulshift_unit: directed and random operations against an arithmetic reference model.
// Expected writes are queued at issue time and checked by an independent monitor on the falling edge.
module tb_exec_mulshift_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [2:0] OP;
  logic [7:0] OPERAND1;
  logic [7:0] OPERAND2;
  logic [2:0] DEST;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
  logic [7:0] RESULT;
  logic [2:0] WADDR;
  logic       WRITE;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  exec_mulshift_unit #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .DEST(DEST),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .RESULT(RESULT),
    .WADDR(WADDR), .WRITE(WRITE), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic on the operation's definition
  function automatic int steps(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd0) return 8;
    if (op == 3'd4) return b % 8;
    return (b >= 8) ? 8 : int'(b);
  endfunction

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [15:0] prod;
    logic signed [7:0] sa;
    logic [15:0] wide;
    n = steps(op, b);
    sa = a;
    case (op)
      3'd0: begin prod = 16'(a) * 16'(b); return prod[7:0]; end
      3'd1: begin wide = 16'(a) << n; return wide[7:0]; end
      3'd2: return 8'(16'(a) >> n);
      3'd3: return 8'(sa >>> n);
      default: begin
        wide = {a, a} >> n;
        return wide[7:0];
      end
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [10:0] e;
    if (!RESET && (WRITE || DONE)) begin
      chk("done_eq_write", 32'(DONE), 32'(WRITE));
      if (WRITE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got waddr %0d result 0x%0h, required no write", WADDR, RESULT);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(RESULT), 32'(e[7:0]));
          chk("waddr", 32'(WADDR), 32'(e[10:8]));
        end
      end
    end
  end

  // driver: called #1 after a rising edge; returns #1 after the edge where BUSY fell
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dest, input bit poke);
    int k;
    int wr_k;
    int wr_cnt;
    int n;
    n = steps(op, b);
    exp_q.push_back({dest, model(op, a, b)});
    OP = op; OPERAND1 = a; OPERAND2 = b; DEST = dest; START = 1'b1;
    @(posedge CLK); #1;
    k = 0; wr_k = -1; wr_cnt = 0;
    while (BUSY && k < 40) begin
      START = poke;
      if (poke) begin
        OP = 3'($urandom_range(0, 4));
        OPERAND1 = 8'($urandom);
        OPERAND2 = 8'($urandom_range(0, 3));
        DEST = 3'($urandom);
      end
      if (WRITE) begin
        wr_k = k;
        wr_cnt++;
      end
      k++;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk("busy_cycles", 32'(k), 32'(n + 2));
    chk("write_cycle", 32'(wr_k), 32'(n + 1));
    chk("write_count", 32'(wr_cnt), 32'd1);
  endtask

  initial begin
    int wr_seen;
    START = 1'b0; OP = '0; OPERAND1 = '0; OPERAND2 = '0; DEST = '0;

    // reset held with START asserted
    RESET = 1'b1; START = 1'b1; OP = 3'd0; OPERAND1 = 8'h33; OPERAND2 = 8'h44; DEST = 3'd6;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_error", 32'(ERROR), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_waddr", 32'(WADDR), 32'd0);
    RESET = 1'b0; START = 1'b0;
    @(posedge CLK); #1;
    chk("rst_no_accept", 32'(BUSY), 32'd0);

    // directed operations
    run_op(3'd0, 8'h0D, 8'h0B, 3'd5, 1'b0);
    run_op(3'd0, 8'hFF, 8'hFF, 3'd3, 1'b0);
    run_op(3'd3, 8'h90, 8'd2, 3'd1, 1'b0);
    run_op(3'd2, 8'h90, 8'd2, 3'd2, 1'b0);
    run_op(3'd1, 8'h81, 8'd9, 3'd4, 1'b0);
    run_op(3'd4, 8'h81, 8'd9, 3'd7, 1'b0);
    run_op(3'd1, 8'h5A, 8'd0, 3'd0, 1'b0);
    run_op(3'd3, 8'h90, 8'd200, 3'd6, 1'b0);

    // START pulsed through RUN and WB of a MUL
    run_op(3'd0, 8'h27, 8'h15, 3'd2, 1'b1);

    // illegal opcode
    OP = 3'b111; OPERAND1 = 8'hAA; OPERAND2 = 8'h01; DEST = 3'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("illegal_error", 32'(ERROR), 32'd1);
    chk("illegal_busy", 32'(BUSY), 32'd0);
    chk("illegal_write", 32'(WRITE), 32'd0);
    wr_seen = 0;
    @(posedge CLK); #1;
    chk("illegal_error_pulse", 32'(ERROR), 32'd0);
    repeat (10) begin
      if (WRITE || BUSY) wr_seen++;
      @(posedge CLK); #1;
    end
    chk("illegal_quiet", 32'(wr_seen), 32'd0);

    // reset after iteration 4 of a MUL
    OP = 3'd0; OPERAND1 = 8'h37; OPERAND2 = 8'h5B; DEST = 3'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_running", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_result", 32'(RESULT), 32'd0);
    chk("abort_waddr", 32'(WADDR), 32'd0);
    wr_seen = 0;
    repeat (20) begin
      if (WRITE || DONE) wr_seen++;
      @(posedge CLK); #1;
    end
    chk("abort_no_write", 32'(wr_seen), 32'd0);

    // back-to-back
    run_op(3'd1, 8'h01, 8'd1, 3'd1, 1'b0);
    run_op(3'd0, 8'h03, 8'h04, 3'd2, 1'b0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      run_op(3'($urandom_range(0, 4)), 8'($urandom), b, 3'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_mulshift_unit.md
Name: exec_mulshift_unit

Overview:
- Multi-cycle execution unit directly downstream of the 8x8 register file.
- Consumes the two read ports (OPERAND1, OPERAND2), iteratively computes a multiply or barrel-free shift/rotate, and drives the register file write port (RESULT, WADDR, WRITE) for one cycle.
- BUSY stalls the control unit/PC while an operation is in flight.

Parameters:
- DATA_W, 8, operand/result width (design and test at 8 only).
- ADDR_W, 3, destination register address width.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RESET  in  1  synchronous, active-high; clock CLK.
- START  in  1  operation request, sampled on posedge only when IDLE.
- OP  in  3  000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR, 101..111 illegal.
- OPERAND1  in  DATA_W  value/multiplicand, from register file OUT1.
- OPERAND2  in  DATA_W  multiplier or shift amount, from OUT2 or immediate.
- DEST  in  ADDR_W  destination register index.
- BUSY  out  1  high in RUN and WB.
- DONE  out  1  one-cycle pulse, coincident with WRITE.
- ERROR  out  1  one-cycle pulse on illegal OP.
- RESULT  out  DATA_W  write data to register file IN.
- WADDR  out  ADDR_W  to register file INADDRESS.
- WRITE  out  1  to register file WRITE, one cycle per operation.

Behaviour:
- All outputs registered. Reset values: BUSY=0, DONE=0, ERROR=0, WRITE=0, RESULT=0, WADDR=0; FSM=IDLE.
- FSM states: IDLE, RUN, WB.
- IDLE, START=1, legal OP at edge E0:
  - Latch OPERAND1, OPERAND2, OP and DEST.
  - Load iteration count N; go to RUN; BUSY=1.
- IDLE, START=1, illegal OP: ERROR=1 for one cycle; stay IDLE; no latch, no WRITE.
- RUN: each edge with count != 0 performs one iteration and decrements count. The edge that sees count == 0 moves to WB.
  - Iterations occur at E1..EN; WB is entered at E(N+1).
- WB: WRITE=1, DONE=1, WADDR=latched DEST, RESULT=final value, all for exactly one cycle. The register file captures at E(N+2); return to IDLE there.
- BUSY is high from E0 to E(N+2), i.e. N+2 cycles.
- After WB, RESULT and WADDR hold their last values; WRITE and DONE return to 0.
- MUL:
  - N=8, unsigned shift-add.
  - Each iteration: if multiplier LSB=1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - RESULT = low 8 bits of the product; overflow silently discarded (same low bits as signed).
- SLL/SRL: shift by 1 per iteration, zero-fill. N = OPERAND2 if < 8, else 8 (result 0).
- SRA: sign-fill. N = min(OPERAND2, 8); amount >= 8 gives 0x00 or 0xFF.
- ROR: N = OPERAND2[2:0]; rotate right by 1 per iteration.
- N=0 (shift amount 0): RUN lasts one cycle; RESULT = OPERAND1 unchanged.
- START while BUSY=1 (including the WB cycle) is ignored, not queued. Inputs may change freely after E0.
- RESET mid-operation: abort at that edge. No WRITE or DONE is issued for the aborted op; all outputs take reset values.
- RESET has priority over START on the same edge.

Test Plan:
- Reset: hold RESET for 2 cycles with START=1 -> BUSY=0, DONE=0, ERROR=0, WRITE=0, RESULT=0x00, WADDR=0; no op accepted.
- MUL 0x0D*0x0B, DEST=5 -> WRITE/DONE high exactly one cycle after E9; RESULT=0x8F, WADDR=5; BUSY high 10 cycles. MUL 0xFF*0xFF -> RESULT=0x01.
- Shifts on 0x90 / 0x81:
  - SRA 0x90 by 2 -> 0xE4.
  - SRL 0x90 by 2 -> 0x24.
  - SLL 0x81 by 9 -> 0x00.
  - ROR 0x81 by 9 -> 0xC0.
  - SLL 0x5A by 0 -> 0x5A, with WRITE after E1.
- START pulsed during RUN and during WB of a MUL -> ignored, exactly one WRITE. OP=111 from IDLE -> ERROR one cycle, WRITE never asserted, BUSY stays 0.
- RESET asserted after iteration 4 of a MUL -> BUSY=0 and RESULT=0 next cycle; no WRITE for 20 following cycles.
- Back-to-back: SLL 0x01 by 1 to DEST=1, then START one cycle after WB with MUL 0x03*0x04 to DEST=2 -> two WRITE pulses: RESULT=0x02 at WADDR 1, then RESULT=0x0C at WADDR 2.
